brq_ifu_id_pipe: RTL and testbench

IF/ID instruction register for the brq core. Each cycle it accepts either a real fetched instruction from the prefetch path or a dummy instruction from `brq_ifu_dummy_instr`, with the dummy taking priority. It registers the winner with its PC and attributes for the ID stage. Its combinational ready output is the `id_in_ready_i` that paces both the dummy generator and fetch.

---
 rtl/brq_pkg.sv | 14 +
 rtl/brq_sat_counter.sv | 23 ++
 rtl/brq_ifu_id_pipe.sv | 110 +++++++++++
 tb/tb_brq_ifu_id_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// Shared types and constants for the brq IF/ID stage.
// Consumers: brq_ifu_id_pipe and the bench (OPCODE_OP matches the dummy generator).
package brq_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        is_dummy;
        logic        fetch_err;
    } if_id_instr_t;

    localparam logic [6:0] OPCODE_OP = 7'h33;

endpackage

// File: rtl/brq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module brq_sat_counter #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             incr,
    output logic [Width-1:0] cnt
);

    // Sticks at all-ones so a long run never wraps back to a small value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (incr && (cnt != {Width{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/brq_ifu_id_pipe.sv
// IF/ID instruction register: a dummy instruction beats a fetched one, the winner is held for ID.
// Optional statistics counters are built when BRQ_IFU_ID_STATS_EN is defined.
module brq_ifu_id_pipe
    import brq_pkg::*;
#(
    parameter int StatsW = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_valid_i,
    input  logic [31:0]       fetch_rdata_i,
    input  logic [31:0]       fetch_addr_i,
    input  logic              fetch_err_i,
    output logic              fetch_ready_o,
    input  logic              insert_dummy_instr_i,
    input  logic [31:0]       dummy_instr_data_i,
    output logic              id_in_ready_o,
    input  logic              flush_i,
    input  logic              id_ready_i,
    output logic              instr_valid_id_o,
    output logic [31:0]       instr_rdata_id_o,
    output logic [31:0]       instr_pc_id_o,
    output logic              instr_is_dummy_o,
    output logic              instr_fetch_err_o,
    input  logic              stats_clr_i,
    output logic [StatsW-1:0] dummy_cnt_o,
    output logic [StatsW-1:0] real_cnt_o
);

    logic         valid_q;
    if_id_instr_t instr_q;
    if_id_instr_t instr_d;
    logic         load_dummy;
    logic         load_real;

    assign id_in_ready_o = ~valid_q | id_ready_i;
    assign load_dummy    = id_in_ready_o & insert_dummy_instr_i & ~flush_i;
    assign load_real     = id_in_ready_o & fetch_valid_i & ~insert_dummy_instr_i & ~flush_i;
    assign fetch_ready_o = load_real;

    // A dummy takes the PC of the real instruction it displaces and never carries an error.
    always_comb begin
        instr_d = instr_q;
        if (load_dummy) begin
            instr_d.rdata     = dummy_instr_data_i;
            instr_d.pc        = fetch_addr_i;
            instr_d.is_dummy  = 1'b1;
            instr_d.fetch_err = 1'b0;
        end else if (load_real) begin
            instr_d.rdata     = fetch_rdata_i;
            instr_d.pc        = fetch_addr_i;
            instr_d.is_dummy  = 1'b0;
            instr_d.fetch_err = fetch_err_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_dummy || load_real) begin
            valid_q <= 1'b1;
        end else if (id_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= '0;
        end else begin
            instr_q <= instr_d;
        end
    end

    assign instr_valid_id_o  = valid_q;
    assign instr_rdata_id_o  = instr_q.rdata;
    assign instr_pc_id_o     = instr_q.pc;
    assign instr_is_dummy_o  = instr_q.is_dummy;
    assign instr_fetch_err_o = instr_q.fetch_err;

`ifdef BRQ_IFU_ID_STATS_EN
    brq_sat_counter #(
        .Width (StatsW)
    ) u_dummy_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (stats_clr_i),
        .incr  (load_dummy),
        .cnt   (dummy_cnt_o)
    );

    brq_sat_counter #(
        .Width (StatsW)
    ) u_real_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (stats_clr_i),
        .incr  (load_real),
        .cnt   (real_cnt_o)
    );
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr_i;
    assign dummy_cnt_o      = '0;
    assign real_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_brq_ifu_id_pipe.sv
// Self-checking bench for brq_ifu_id_pipe: vector table through a scoreboard, then stats and reset sequences.
module tb_brq_ifu_id_pipe;
    import brq_pkg::*;

    localparam int StatsW = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              fetch_valid_i;
    logic [31:0]       fetch_rdata_i;
    logic [31:0]       fetch_addr_i;
    logic              fetch_err_i;
    logic              fetch_ready_o;
    logic              insert_dummy_instr_i;
    logic [31:0]       dummy_instr_data_i;
    logic              id_in_ready_o;
    logic              flush_i;
    logic              id_ready_i;
    logic              instr_valid_id_o;
    logic [31:0]       instr_rdata_id_o;
    logic [31:0]       instr_pc_id_o;
    logic              instr_is_dummy_o;
    logic              instr_fetch_err_o;
    logic              stats_clr_i;
    logic [StatsW-1:0] dummy_cnt_o;
    logic [StatsW-1:0] real_cnt_o;

    brq_ifu_id_pipe #(.StatsW(StatsW)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .fetch_valid_i        (fetch_valid_i),
        .fetch_rdata_i        (fetch_rdata_i),
        .fetch_addr_i         (fetch_addr_i),
        .fetch_err_i          (fetch_err_i),
        .fetch_ready_o        (fetch_ready_o),
        .insert_dummy_instr_i (insert_dummy_instr_i),
        .dummy_instr_data_i   (dummy_instr_data_i),
        .id_in_ready_o        (id_in_ready_o),
        .flush_i              (flush_i),
        .id_ready_i           (id_ready_i),
        .instr_valid_id_o     (instr_valid_id_o),
        .instr_rdata_id_o     (instr_rdata_id_o),
        .instr_pc_id_o        (instr_pc_id_o),
        .instr_is_dummy_o     (instr_is_dummy_o),
        .instr_fetch_err_o    (instr_fetch_err_o),
        .stats_clr_i          (stats_clr_i),
        .dummy_cnt_o          (dummy_cnt_o),
        .real_cnt_o           (real_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        is_dummy;
        logic        err;
    } reg_exp_t;

    typedef struct {
        logic        fetch_valid;
        logic [31:0] fetch_rdata;
        logic [31:0] fetch_addr;
        logic        fetch_err;
        logic        insert;
        logic [31:0] dummy_data;
        logic        flush;
        logic        id_ready;
        logic        exp_in_ready;
        logic        exp_fetch_ready;
        reg_exp_t    exp_reg;
    } vec_t;

    int       checks = 0;
    int       failures = 0;
    reg_exp_t sb_q[$];
    vec_t     tbl[$];

    function automatic vec_t mk(logic fv, logic [31:0] fr, logic [31:0] fa, logic fe,
                                logic ins, logic [31:0] dd, logic fl, logic idr,
                                logic eir, logic efr, logic ev, logic [31:0] erd,
                                logic [31:0] epc, logic edum, logic eerr);
        vec_t v;
        v.fetch_valid = fv;  v.fetch_rdata = fr; v.fetch_addr = fa; v.fetch_err = fe;
        v.insert = ins;      v.dummy_data = dd;  v.flush = fl;      v.id_ready = idr;
        v.exp_in_ready = eir; v.exp_fetch_ready = efr;
        v.exp_reg.valid = ev; v.exp_reg.rdata = erd; v.exp_reg.pc = epc;
        v.exp_reg.is_dummy = edum; v.exp_reg.err = eerr;
        return v;
    endfunction

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkReg(input string name, input reg_exp_t e);
        checks++;
        if (instr_valid_id_o !== e.valid || instr_rdata_id_o !== e.rdata || instr_pc_id_o !== e.pc ||
            instr_is_dummy_o !== e.is_dummy || instr_fetch_err_o !== e.err) begin
            failures++;
            $display("[TB] FAIL %s: got v=%b rd=%h pc=%h dum=%b err=%b expected v=%b rd=%h pc=%h dum=%b err=%b",
                     name, instr_valid_id_o, instr_rdata_id_o, instr_pc_id_o, instr_is_dummy_o,
                     instr_fetch_err_o, e.valid, e.rdata, e.pc, e.is_dummy, e.err);
        end
    endtask

    task automatic checkCounters(input string name, input logic [StatsW-1:0] dexp, input logic [StatsW-1:0] rexp);
        checks++;
        if (dummy_cnt_o !== dexp || real_cnt_o !== rexp) begin
            failures++;
            $display("[TB] FAIL %s: got dummy=%0d real=%0d expected dummy=%0d real=%0d",
                     name, dummy_cnt_o, real_cnt_o, dexp, rexp);
        end
    endtask

    // Drive one vector at the falling edge, check the combinational readies, queue the registered result.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk_i);
        fetch_valid_i        = v.fetch_valid;
        fetch_rdata_i        = v.fetch_rdata;
        fetch_addr_i         = v.fetch_addr;
        fetch_err_i          = v.fetch_err;
        insert_dummy_instr_i = v.insert;
        dummy_instr_data_i   = v.dummy_data;
        flush_i              = v.flush;
        id_ready_i           = v.id_ready;
        #1;
        checkBit($sformatf("vec%0d id_in_ready", idx), id_in_ready_o, v.exp_in_ready);
        checkBit($sformatf("vec%0d fetch_ready", idx), fetch_ready_o, v.exp_fetch_ready);
        sb_q.push_back(v.exp_reg);
    endtask

    task automatic checkOutput(input int idx);
        reg_exp_t e;
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL vec%0d scoreboard: got empty queue expected one entry", idx);
        end else begin
            e = sb_q.pop_front();
            checkReg($sformatf("vec%0d registered", idx), e);
        end
    endtask

    task automatic idleInputs();
        fetch_valid_i = 0; fetch_rdata_i = '0; fetch_addr_i = '0; fetch_err_i = 0;
        insert_dummy_instr_i = 0; dummy_instr_data_i = '0; flush_i = 0; id_ready_i = 0;
    endtask

    logic [StatsW-1:0] exp_dummy_sat;
    logic [StatsW-1:0] exp_real3;
    reg_exp_t          zero_reg;

    initial begin
        rst_i = 1'b1;
        stats_clr_i = 1'b0;
        idleInputs();
        zero_reg = '{valid: 1'b0, rdata: 32'h0, pc: 32'h0, is_dummy: 1'b0, err: 1'b0};

        // Vector table; expected values follow from the stage's load/valid rules.
        tbl.push_back(mk(1, 32'h00A00513, 32'h100, 0, 0, 32'h0,        0, 1, 1, 1, 1, 32'h00A00513, 32'h100, 0, 0));
        tbl.push_back(mk(1, 32'h00B00593, 32'h104, 0, 1, 32'h02B50033, 0, 1, 1, 0, 1, 32'h02B50033, 32'h104, 1, 0));
        tbl.push_back(mk(1, 32'h00B00593, 32'h104, 0, 0, 32'h0,        0, 1, 1, 1, 1, 32'h00B00593, 32'h104, 0, 0));
        tbl.push_back(mk(1, 32'h00C00613, 32'h108, 1, 0, 32'h0,        0, 1, 1, 1, 1, 32'h00C00613, 32'h108, 0, 1));
        tbl.push_back(mk(1, 32'h00000013, 32'h10C, 1, 1, 32'h00000033, 0, 1, 1, 0, 1, 32'h00000033, 32'h10C, 1, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 32'h00D00693, 32'h110, 0, 1, 32'h0AB00033, 0, 0, 0, 0, 1, 32'h00000033, 32'h10C, 1, 0));
        tbl.push_back(mk(1, 32'h00D00693, 32'h110, 0, 1, 32'h0AB00033, 1, 0, 0, 0, 0, 32'h00000033, 32'h10C, 1, 0));
        tbl.push_back(mk(0, 32'h0,        32'h0,   0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h00000033, 32'h10C, 1, 0));
        tbl.push_back(mk(1, 32'h00D00693, 32'h110, 0, 0, 32'h0,        0, 0, 1, 1, 1, 32'h00D00693, 32'h110, 0, 0));
        tbl.push_back(mk(0, 32'h0,        32'h0,   0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h00D00693, 32'h110, 0, 0));
        tbl.push_back(mk(0, 32'h0,        32'h0,   0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h00D00693, 32'h110, 0, 0));
        tbl.push_back(mk(1, 32'h00E00713, 32'h114, 0, 1, 32'h0CD00033, 1, 1, 1, 0, 0, 32'h00D00693, 32'h110, 0, 0));
        tbl.push_back(mk(1, 32'h00E00713, 32'h114, 0, 0, 32'h0,        0, 1, 1, 1, 1, 32'h00E00713, 32'h114, 0, 0));
        tbl.push_back(mk(0, 32'h0,        32'h0,   0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h00E00713, 32'h114, 0, 0));

        // Reset state, including the ready path with nothing registered.
        #12;
        checkReg("reset registers", zero_reg);
        checkBit("reset id_in_ready", id_in_ready_o, 1'b1);
        checkCounters("reset counters", '0, '0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], i);
            checkOutput(i);
        end

        // Statistics: clear, saturate the dummy counter, count a few real loads, then clear during a load.
`ifdef BRQ_IFU_ID_STATS_EN
        exp_dummy_sat = {StatsW{1'b1}};
        exp_real3     = StatsW'(3);
`else
        exp_dummy_sat = '0;
        exp_real3     = '0;
`endif
        @(negedge clk_i);
        idleInputs();
        stats_clr_i = 1'b1;
        @(posedge clk_i); #1;
        checkCounters("stats clear", '0, '0);
        @(negedge clk_i);
        stats_clr_i = 1'b0;
        id_ready_i = 1'b1;
        fetch_valid_i = 1'b1;
        insert_dummy_instr_i = 1'b1;
        dummy_instr_data_i = 32'h02B50033;
        for (int i = 0; i < 20; i++) begin
            fetch_addr_i = 32'h200 + 32'(4 * i);
            @(posedge clk_i); #1;
            @(negedge clk_i);
        end
        checkCounters("dummy saturation", exp_dummy_sat, '0);
        checkBit("dummy opcode", instr_rdata_id_o[6:0] == OPCODE_OP, 1'b1);
        insert_dummy_instr_i = 1'b0;
        fetch_rdata_i = 32'h00F00793;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
        end
        checkCounters("real count", exp_dummy_sat, exp_real3);
        stats_clr_i = 1'b1;
        @(posedge clk_i); #1;
        checkCounters("clear beats load", '0, '0);
        checkBit("load during clear valid", instr_valid_id_o, 1'b1);

        // Asynchronous reset mid-stream with a valid instruction registered.
        @(negedge clk_i);
        stats_clr_i = 1'b0;
        id_ready_i = 1'b0;
        @(posedge clk_i); #3;
        checkBit("pre-reset valid", instr_valid_id_o, 1'b1);
        rst_i = 1'b1;
        #1;
        checkReg("async reset registers", zero_reg);
        checkCounters("async reset counters", '0, '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idleInputs();
        #1;
        checkBit("post-reset id_in_ready", id_in_ready_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
